// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the multi-channel PWM block.
// Latency: n/a (constants and combinational helper only).
// Backpressure: n/a.
package pwm_pkg;

  localparam logic MODE_EDGE   = 1'b0;
  localparam logic MODE_CENTER = 1'b1;

  // Counter direction states
  localparam logic [0:0] DIR_UP   = 1'b0;
  localparam logic [0:0] DIR_DOWN = 1'b1;

  // Upper bounds for the duty slice helper: WIDTH <= 32, NCH <= 32
  localparam int MAX_W   = 32;
  localparam int MAX_NCH = 32;
  localparam int MAX_BUS = MAX_W * MAX_NCH;

  // Returns channel idx of a flattened duty bus (channel i at [i*width +: width]).
  // The caller zero-extends the bus to MAX_BUS and truncates the result to its width.
  function automatic logic [MAX_W-1:0] duty_slice(input logic [MAX_BUS-1:0] bus,
                                                  input int width,
                                                  input int idx);
    logic [MAX_BUS-1:0] w_sh;
    w_sh = bus >> (idx * width);
    return w_sh[MAX_W-1:0];
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: active duty/polarity registers, compare, polarity XOR, output flop.
// Latency: one cycle from counter value to pin.
// Backpressure: none; active registers load only on the parent's boundary strobe.
module pwm_channel #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_cnt,
  input  logic [WIDTH-1:0] i_duty,
  input  logic             i_pol,
  output logic             o_pwm
);

  logic [WIDTH-1:0] r_duty;
  logic             r_pol;
  logic             r_pwm;
  logic             w_raw;

  // Counter below duty drives the active level; duty 0 never fires, duty > period always fires
  assign w_raw = (i_cnt < r_duty);

  // Active duty/polarity change only when the parent signals a boundary with pending config
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_duty <= '0;
      r_pol  <= 1'b0;
    end else if (i_load) begin
      r_duty <= i_duty;
      r_pol  <= i_pol;
    end
  end

  // Registered pin: modulated while running, parked at the idle (polarity) level when stopped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwm <= 1'b0;
    end else begin
      r_pwm <= i_en ? (w_raw ^ r_pol) : r_pol;
    end
  end

  assign o_pwm = r_pwm;

endmodule

// File: rtl/pwm_multi.sv
// NCH-channel PWM with shared period counter, shadowed config applied at period boundaries.
// Latency: one cycle from counter to pwm_out/period_start; config takes effect at next boundary.
// Backpressure: none; cfg_we always accepted, a write while pending overwrites the shadow.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NCH   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 mode,
  input  logic                 cfg_we,
  input  logic [WIDTH-1:0]     cfg_period,
  input  logic [NCH*WIDTH-1:0] cfg_duty,
  input  logic [NCH-1:0]       cfg_pol,
  output logic                 cfg_pending,
  output logic                 period_start,
  output logic [NCH-1:0]       pwm_out
);

  logic [WIDTH-1:0]     r_cnt;
  logic [0:0]           r_dir;
  logic [WIDTH-1:0]     r_period;
  logic                 r_mode;
  logic [WIDTH-1:0]     r_sh_period;
  logic [NCH*WIDTH-1:0] r_sh_duty;
  logic [NCH-1:0]       r_sh_pol;
  logic                 r_pending;
  logic                 r_pstart;

  logic [WIDTH-1:0]     w_cnt_nxt;
  logic [0:0]           w_dir_nxt;
  logic                 w_boundary;
  logic                 w_load;
  logic [WIDTH-1:0]     w_sh_duty [NCH];

  // Next counter value and direction; a stopped counter parks at 0 counting up
  always_comb begin
    w_cnt_nxt = '0;
    w_dir_nxt = DIR_UP;
    if (en) begin
      if (r_mode == MODE_EDGE) begin
        if (r_cnt < r_period) w_cnt_nxt = r_cnt + WIDTH'(1);
      end else if (r_dir == DIR_UP) begin
        if (r_cnt < r_period) begin
          w_cnt_nxt = r_cnt + WIDTH'(1);
        end else if (r_period > WIDTH'(1)) begin
          // Peak reached: turn around; P=1 falls straight back to 0 (period of 2)
          w_cnt_nxt = r_period - WIDTH'(1);
          w_dir_nxt = DIR_DOWN;
        end
      end else begin
        w_cnt_nxt = r_cnt - WIDTH'(1);
        w_dir_nxt = (r_cnt > WIDTH'(1)) ? DIR_DOWN : DIR_UP;
      end
    end
  end

  // Any edge that lands the counter on 0 starts a period, including every stopped or P=0 edge
  assign w_boundary = (w_cnt_nxt == '0);
  assign w_load     = w_boundary & r_pending;

  // Counter and direction state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_dir <= DIR_UP;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_dir <= w_dir_nxt;
    end
  end

  // Shared active period and mode, swapped in only at a boundary so no period is truncated
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_period <= '0;
      r_mode   <= MODE_EDGE;
    end else if (w_load) begin
      r_period <= r_sh_period;
      r_mode   <= mode;
    end
  end

  // Shadow registers capture every write; a same-edge transfer still sees the old shadow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh_period <= '0;
      r_sh_duty   <= '0;
      r_sh_pol    <= '0;
    end else if (cfg_we) begin
      r_sh_period <= cfg_period;
      r_sh_duty   <= cfg_duty;
      r_sh_pol    <= cfg_pol;
    end
  end

  // Pending flag: a write always wins over a transfer on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= 1'b0;
    end else if (cfg_we) begin
      r_pending <= 1'b1;
    end else if (w_load) begin
      r_pending <= 1'b0;
    end
  end

  // Period start aligned with the pins: flags the cycle whose compared count was 0 going up
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pstart <= 1'b0;
    end else begin
      r_pstart <= en & (r_cnt == '0) & (r_dir == DIR_UP);
    end
  end

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    assign w_sh_duty[gi] = WIDTH'(duty_slice(MAX_BUS'(r_sh_duty), WIDTH, gi));

    pwm_channel #(
      .WIDTH (WIDTH)
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_en   (en),
      .i_load (w_load),
      .i_cnt  (r_cnt),
      .i_duty (w_sh_duty[gi]),
      .i_pol  (r_sh_pol[gi]),
      .o_pwm  (pwm_out[gi])
    );
  end

  assign cfg_pending  = r_pending;
  assign period_start = r_pstart;

endmodule

// File: tb/tb_pwm_multi.sv
// Directed bench for pwm_multi (WIDTH=8, NCH=2) with hand-computed waveforms.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: n/a; every run is a fixed number of cycles.
module tb_pwm_multi;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        mode;
  logic        cfg_we;
  logic [7:0]  cfg_period;
  logic [15:0] cfg_duty;
  logic [1:0]  cfg_pol;
  logic        cfg_pending;
  logic        period_start;
  logic [1:0]  pwm_out;

  int n_tests = 0;
  int n_fail  = 0;

  pwm_multi #(.WIDTH(8), .NCH(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .mode         (mode),
    .cfg_we       (cfg_we),
    .cfg_period   (cfg_period),
    .cfg_duty     (cfg_duty),
    .cfg_pol      (cfg_pol),
    .cfg_pending  (cfg_pending),
    .period_start (period_start),
    .pwm_out      (pwm_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load a configuration while stopped; leaves it applied and the pins at the idle level
  task automatic cfg_stopped(input logic [7:0] p, input logic [7:0] d1, input logic [7:0] d0,
                             input logic [1:0] pol, input logic md);
    en = 1'b0; mode = md;
    cfg_period = p; cfg_duty = {d1, d0}; cfg_pol = pol;
    cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; mode = 1'b0; cfg_we = 1'b0;
    cfg_period = '0; cfg_duty = '0; cfg_pol = '0;
    #1;
    tick();
    n_tests++;
    if ({cfg_pending, period_start, pwm_out} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_outputs got=%b exp=0000", {cfg_pending, period_start, pwm_out});
    end
    rst_n = 1'b1;
    tick();
    n_tests++;
    if ({cfg_pending, period_start, pwm_out} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_release_idle got=%b exp=0000", {cfg_pending, period_start, pwm_out});
    end
  endtask

  task automatic test_edge_basic();
    logic e0, eps;
    en = 1'b1; mode = 1'b0;
    cfg_period = 8'd9; cfg_duty = {8'd0, 8'd3}; cfg_pol = 2'b00;
    cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
    n_tests++;
    if (cfg_pending !== 1'b1) begin
      n_fail++; $display("FAIL edge_pending_set got=%b exp=1", cfg_pending);
    end
    tick();
    n_tests++;
    if (cfg_pending !== 1'b0) begin
      n_fail++; $display("FAIL edge_pending_clr got=%b exp=0", cfg_pending);
    end
    for (int k = 0; k < 20; k++) begin
      tick();
      e0  = ((k % 10) < 3);
      eps = ((k % 10) == 0);
      n_tests++;
      if (pwm_out[0] !== e0) begin
        n_fail++; $display("FAIL edge_pwm0 k=%0d got=%b exp=%b", k, pwm_out[0], e0);
      end
      n_tests++;
      if (pwm_out[1] !== 1'b0) begin
        n_fail++; $display("FAIL edge_pwm1 k=%0d got=%b exp=0", k, pwm_out[1]);
      end
      n_tests++;
      if (period_start !== eps) begin
        n_fail++; $display("FAIL edge_pstart k=%0d got=%b exp=%b", k, period_start, eps);
      end
    end
  endtask

  task automatic test_center();
    logic pat [8];
    logic eps;
    pat = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    cfg_stopped(8'd4, 8'd5, 8'd2, 2'b00, 1'b1);
    en = 1'b1;
    for (int k = 0; k < 16; k++) begin
      tick();
      eps = ((k % 8) == 0);
      n_tests++;
      if (pwm_out !== {1'b1, pat[k % 8]}) begin
        n_fail++; $display("FAIL center_pwm k=%0d got=%b exp=%b", k, pwm_out, {1'b1, pat[k % 8]});
      end
      n_tests++;
      if (period_start !== eps) begin
        n_fail++; $display("FAIL center_pstart k=%0d got=%b exp=%b", k, period_start, eps);
      end
    end
  endtask

  task automatic test_mid_period_write();
    logic e0, ep;
    cfg_stopped(8'd9, 8'd0, 8'd3, 2'b00, 1'b0);
    en = 1'b1;
    for (int j = 1; j <= 20; j++) begin
      if (j == 5) begin
        cfg_duty = {8'd0, 8'd7}; cfg_we = 1'b1;
      end
      tick();
      cfg_we = 1'b0;
      e0 = (j <= 10) ? ((j - 1) < 3) : ((j - 11) < 7);
      ep = (j >= 5) && (j <= 9);
      n_tests++;
      if (pwm_out[0] !== e0) begin
        n_fail++; $display("FAIL mid_pwm0 j=%0d got=%b exp=%b", j, pwm_out[0], e0);
      end
      n_tests++;
      if (cfg_pending !== ep) begin
        n_fail++; $display("FAIL mid_pending j=%0d got=%b exp=%b", j, cfg_pending, ep);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic e0, ep;
    cfg_stopped(8'd9, 8'd0, 8'd3, 2'b00, 1'b0);
    en = 1'b1;
    for (int j = 1; j <= 30; j++) begin
      if (j == 3) begin
        cfg_duty = {8'd0, 8'd5}; cfg_we = 1'b1;
      end
      if (j == 10) begin
        cfg_duty = {8'd0, 8'd8}; cfg_we = 1'b1;
      end
      tick();
      cfg_we = 1'b0;
      if (j <= 10)      e0 = ((j - 1) < 3);
      else if (j <= 20) e0 = ((j - 11) < 5);
      else              e0 = ((j - 21) < 8);
      ep = (j >= 3) && (j <= 19);
      n_tests++;
      if (pwm_out[0] !== e0) begin
        n_fail++; $display("FAIL b2b_pwm0 j=%0d got=%b exp=%b", j, pwm_out[0], e0);
      end
      n_tests++;
      if (cfg_pending !== ep) begin
        n_fail++; $display("FAIL b2b_pending j=%0d got=%b exp=%b", j, cfg_pending, ep);
      end
    end
  endtask

  task automatic test_edge_cases();
    // D0=0 never high, D1=10 > P=9 always high
    cfg_stopped(8'd9, 8'd10, 8'd0, 2'b00, 1'b0);
    en = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      n_tests++;
      if (pwm_out !== 2'b10) begin
        n_fail++; $display("FAIL limits_pwm k=%0d got=%b exp=10", k, pwm_out);
      end
    end
    // Same duties inverted; idle level checked first
    cfg_stopped(8'd9, 8'd10, 8'd0, 2'b11, 1'b0);
    n_tests++;
    if (pwm_out !== 2'b11) begin
      n_fail++; $display("FAIL inv_idle got=%b exp=11", pwm_out);
    end
    en = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      n_tests++;
      if (pwm_out !== 2'b01) begin
        n_fail++; $display("FAIL inv_pwm k=%0d got=%b exp=01", k, pwm_out);
      end
    end
    // P=0: every cycle is a period start, D0=1 always high
    cfg_stopped(8'd0, 8'd0, 8'd1, 2'b00, 1'b0);
    en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      n_tests++;
      if ({period_start, pwm_out} !== 3'b101) begin
        n_fail++; $display("FAIL p0_out k=%0d got=%b exp=101", k, {period_start, pwm_out});
      end
    end
  endtask

  task automatic test_async_reset();
    logic e0, eps;
    cfg_stopped(8'd9, 8'd3, 8'd3, 2'b10, 1'b0);
    en = 1'b1;
    tick(); tick(); tick();
    n_tests++;
    if (pwm_out !== 2'b01) begin
      n_fail++; $display("FAIL ar_pre_pwm got=%b exp=01", pwm_out);
    end
    cfg_duty = {8'd1, 8'd1}; cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
    n_tests++;
    if (cfg_pending !== 1'b1) begin
      n_fail++; $display("FAIL ar_pre_pending got=%b exp=1", cfg_pending);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({cfg_pending, period_start, pwm_out} !== 4'b0000) begin
      n_fail++; $display("FAIL ar_async got=%b exp=0000", {cfg_pending, period_start, pwm_out});
    end
    en = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_tests++;
      if ({period_start, pwm_out} !== 3'b000) begin
        n_fail++; $display("FAIL ar_stopped k=%0d got=%b exp=000", k, {period_start, pwm_out});
      end
    end
    cfg_stopped(8'd9, 8'd0, 8'd3, 2'b01, 1'b0);
    for (int k = 0; k < 2; k++) begin
      tick();
      n_tests++;
      if ({period_start, pwm_out} !== 3'b001) begin
        n_fail++; $display("FAIL ar_idle_pol k=%0d got=%b exp=001", k, {period_start, pwm_out});
      end
    end
    en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      e0  = (k < 3) ^ 1'b1;
      eps = (k == 0);
      n_tests++;
      if ({period_start, pwm_out} !== {eps, 1'b0, e0}) begin
        n_fail++; $display("FAIL ar_restart k=%0d got=%b exp=%b", k, {period_start, pwm_out}, {eps, 1'b0, e0});
      end
    end
  endtask

  initial begin
    test_reset();
    test_edge_basic();
    test_center();
    test_mid_period_write();
    test_back_to_back();
    test_edge_cases();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_multi.md
Name: pwm_multi

Overview:
Multi-channel PWM generator. It is the parametrised successor to the single-channel low/high-time modulator. NCH channels share one period counter. Each channel has its own duty compare and output polarity. Period and duty writes go to shadow registers and become active only at a period boundary, so the block never produces a glitched or truncated pulse. It supports edge-aligned and center-aligned counting and sits between a register/control block and the output pins.

Parameters:
WIDTH, 16, bit width of the counter, period and each duty value
NCH, 4, number of output channels (1..32)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en  in  1  run enable; when 0 the counter is held at 0
mode  in  1  0 = edge-aligned, 1 = center-aligned; sampled only at a boundary
cfg_we  in  1  single-cycle write strobe; latches cfg_period, cfg_duty and cfg_pol into the shadow registers
cfg_period  in  WIDTH  new period value
cfg_duty  in  NCH*WIDTH  new duty values; channel i occupies bits [i*WIDTH +: WIDTH]
cfg_pol  in  NCH  new per-channel polarity; 1 = inverted output
cfg_pending  out  1  shadow holds values not yet applied
period_start  out  1  one-cycle pulse aligned with the first output cycle of each period
pwm_out  out  NCH  PWM outputs

Behaviour:
- Reset (async, rst_n=0):
  - cnt, direction, active period, active duty, active polarity, active mode, shadows: all 0.
  - cfg_pending=0, period_start=0, pwm_out=0.
- Edge-aligned counting: cnt goes 0,1,...,P,0,... (P = active period); period length P+1 cycles.
- Center-aligned counting: cnt goes up 0..P, then down P-1..1, then 0; period length 2P cycles.
- P=0, either mode: cnt stays 0 and every cycle is a boundary.
- Boundary: the clock edge on which cnt becomes 0, or every edge while cnt is held at 0.
- At a boundary with cfg_pending=1:
  - shadow -> active for period, duty, polarity, and mode is latched.
  - cfg_pending cleared.
  - The first cycle of the new period already uses the new values.
- cfg_we:
  - Writes all shadows and sets cfg_pending.
  - A write while pending overwrites the shadow; only the last write is applied.
  - A write on the same edge as a boundary transfer: the transfer uses the pre-write shadow, the new write lands in the shadow, and cfg_pending stays 1.
- en=0:
  - cnt forced to 0, direction up.
  - Active registers load from the shadow on every edge where pending=1, so config is immediate while stopped.
  - pwm_out[i] = active pol[i], the idle level.
  - period_start=0.
- en 0->1: counting starts from cnt=0; the first running cycle is a period start.
- Compare per channel: raw_i = (cnt < D_i), unsigned WIDTH-bit compare.
  - D_i=0: always low.
  - D_i > P (edge) or D_i > P (center): always high.
  - No wrap or overflow: cnt never exceeds P, and P = 2^WIDTH-1 is legal.
- Output:
  - pwm_out[i] registered: pwm_out[i] <= raw_i XOR pol_i when en=1.
  - One cycle latency from cnt to pin.
  - period_start registered with the same latency, high when the compared cnt was 0 and direction was up (edge mode: every cnt=0).
- Duty changes never shorten or lengthen a pulse mid-period; all channels switch on the same cycle.
- Mode change takes effect only at a boundary. Center mode restarts counting up from 0.

Decomposition:
- Package pwm_pkg:
  - MODE_EDGE=1'b0, MODE_CENTER=1'b1.
  - Helper function to slice channel i out of the flattened duty bus.
- One sub-module, pwm_channel (WIDTH):
  - Holds the active duty and polarity registers.
  - Performs the compare, XOR and output register.
  - Instantiated NCH times in a generate loop.
- Top level holds the counter, direction FSM (UP/DOWN), shadow registers and the pending/boundary logic.

Test Plan:
1. WIDTH=8, NCH=2; write P=9, D0=3, D1=0, pol=0, en=1 -> pwm_out[0] high 3 of every 10 cycles, pwm_out[1] always 0, period_start every 10 cycles, cfg_pending cleared at the first boundary.
2. Center mode, P=4, D0=2 -> 8-cycle period, pwm_out[0] pattern H H L L L L L H from period_start, symmetric about cnt=0.
3. Mid-period write D0=7 at cnt=4 (P=9, D0=3) -> current period still 3 high; next period 7 high; cfg_pending=1 until that boundary.
4. cfg_we on the exact boundary edge -> the old shadow is applied, the new value is applied one period later, cfg_pending stays 1 across that boundary.
5. Edge cases: D0=0 -> constant 0; D0=10 with P=9 -> constant 1; pol0=1 inverts both; P=0 with D0=1 -> constant 1 and period_start=1 every cycle.
6. Assert rst_n=0 mid-period -> pwm_out=0, cfg_pending=0 immediately (async). After release with en=0, pwm_out equals the idle polarity and the counter does not advance.
